alu_writeback_regfile: RTL and testbench

- Register file with a registered write-back stage, sitting directly around the 16-bit ALU.
- Two asynchronous read ports supply the ALU operands (in1, in2).
- The write port captures the ALU result into a pending write-back register, then commits it to the array on the next edge.
- Pending data is forwarded to the read ports, and the ALU zero flag is latched into a status bit for branch decisions.

---
 rtl/cpu_defs_pkg.sv | 19 +
 rtl/regfile_fwd_port.sv | 24 ++
 rtl/alu_writeback_regfile.sv | 89 ++++++++
 tb/tb_alu_writeback_regfile.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: datapath widths and the ALU operation encoding,
// so the decoder, the ALU and the register file agree on sizes and opcodes.
package cpu_defs_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef enum logic [2:0] {
    ALU_MOVE = 3'd0,
    ALU_ADD  = 3'd1,
    ALU_SUB  = 3'd2,
    ALU_AND  = 3'd3,
    ALU_OR   = 3'd4,
    ALU_NOT  = 3'd5,
    ALU_NOP  = 3'd7
  } alu_op_e;

endpackage

// File: rtl/regfile_fwd_port.sv
// One asynchronous register-file read port; returns the pending write-back
// data instead of the array word when the pending entry targets this address.
module regfile_fwd_port #(
  parameter int DATA_W = cpu_defs_pkg::DATA_W,
  parameter int ADDR_W = cpu_defs_pkg::ADDR_W
) (
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              pend_valid,
  input  logic [ADDR_W-1:0] pend_addr,
  input  logic [DATA_W-1:0] pend_data,
  output logic [DATA_W-1:0] rd_data
);

  // Forwarding uses only registered pending state, never wb_data/wb_en, so
  // the ALU -> register file -> ALU path stays free of combinational loops.
  always_comb begin
    // NOTE: always_comb outputs get a default first so no path leaves them
    // unassigned; an unassigned path would infer a latch.
    rd_data = mem_data;
    if (pend_valid && (pend_addr == rd_addr)) rd_data = pend_data;
  end

endmodule

// File: rtl/alu_writeback_regfile.sv
// Register file around the 16-bit ALU: two forwarded async read ports, a
// one-entry registered write-back stage, and a latched zero flag.
module alu_writeback_regfile #(
  parameter int DATA_W = cpu_defs_pkg::DATA_W,
  parameter int ADDR_W = cpu_defs_pkg::ADDR_W,
  parameter int DEPTH  = cpu_defs_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flag_en,
  input  logic              zero_in,
  output logic              zero_q,
  output logic              wb_pending
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              pend_valid;
  logic [ADDR_W-1:0] pend_addr;
  logic [DATA_W-1:0] pend_data;

  wire capture = wb_en && !hold;

  // NOTE: the array is built from flops and must read zero after reset, so it
  // is cleared in the reset branch; a RAM macro could not be reset this way.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (pend_valid) begin
      mem[pend_addr] <= pend_data;
    end
  end

  // Commit (above) and capture share an edge, so back-to-back writes need
  // no bubble; a reset drops the pending entry without committing it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      pend_valid <= 1'b0;
      pend_addr  <= '0;
      pend_data  <= '0;
    end else if (capture) begin
      pend_valid <= 1'b1;
      pend_addr  <= wb_addr;
      pend_data  <= wb_data;
    end else begin
      pend_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)                 zero_q <= 1'b0;
    else if (flag_en && !hold) zero_q <= zero_in;
  end

  assign wb_pending = pend_valid;

  logic [DATA_W-1:0] mem_data1;
  logic [DATA_W-1:0] mem_data2;
  assign mem_data1 = mem[rd_addr1];
  assign mem_data2 = mem[rd_addr2];

  regfile_fwd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port1 (
    .rd_addr    (rd_addr1),
    .mem_data   (mem_data1),
    .pend_valid (pend_valid),
    .pend_addr  (pend_addr),
    .pend_data  (pend_data),
    .rd_data    (rd_data1)
  );

  regfile_fwd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port2 (
    .rd_addr    (rd_addr2),
    .mem_data   (mem_data2),
    .pend_valid (pend_valid),
    .pend_addr  (pend_addr),
    .pend_data  (pend_data),
    .rd_data    (rd_data2)
  );

endmodule

// File: tb/tb_alu_writeback_regfile.sv
// Self-checking bench for alu_writeback_regfile: a reference model predicts
// post-edge outputs, which are queued at drive time and compared after the edge.
module tb_alu_writeback_regfile;
  import cpu_defs_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              hold;
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              flag_en;
  logic              zero_in;
  logic              zero_q;
  logic              wb_pending;

  always #5 clk = ~clk;

  alu_writeback_regfile dut (
    .clk        (clk),
    .rst        (rst),
    .hold       (hold),
    .rd_addr1   (rd_addr1),
    .rd_addr2   (rd_addr2),
    .rd_data1   (rd_data1),
    .rd_data2   (rd_data2),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .flag_en    (flag_en),
    .zero_in    (zero_in),
    .zero_q     (zero_q),
    .wb_pending (wb_pending)
  );

  typedef struct {
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic              zq;
    logic              pend;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  logic [DATA_W-1:0] m_mem [DEPTH];
  logic              m_pv;
  logic [ADDR_W-1:0] m_pa;
  logic [DATA_W-1:0] m_pd;
  logic              m_zq;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] m_read(input logic [ADDR_W-1:0] a);
    return (m_pv && m_pa == a) ? m_pd : m_mem[a];
  endfunction

  // Advances the model by one edge using the inputs currently driven.
  task automatic model_edge();
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      m_pv = 1'b0; m_pa = '0; m_pd = '0; m_zq = 1'b0;
    end else begin
      if (m_pv) m_mem[m_pa] = m_pd;
      if (wb_en && !hold) begin
        m_pv = 1'b1; m_pa = wb_addr; m_pd = wb_data;
      end else begin
        m_pv = 1'b0;
      end
      if (flag_en && !hold) m_zq = zero_in;
    end
  endtask

  // One clock: predict, queue, clock, then pop and compare.
  task automatic step(input string tag);
    exp_t e;
    exp_t got;
    model_edge();
    e.rd1 = m_read(rd_addr1);
    e.rd2 = m_read(rd_addr2);
    e.zq  = m_zq;
    e.pend = m_pv;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      got = sb_q.pop_front();
      check({tag, "_rd1"}, 32'(rd_data1), 32'(got.rd1));
      check({tag, "_rd2"}, 32'(rd_data2), 32'(got.rd2));
      check({tag, "_zero_q"}, 32'(zero_q), 32'(got.zq));
      check({tag, "_pending"}, 32'(wb_pending), 32'(got.pend));
    end
  endtask

  task automatic idle();
    rst = 1'b1; hold = 1'b0; wb_en = 1'b0; flag_en = 1'b0; zero_in = 1'b0;
  endtask

  task automatic write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
  endtask

  initial begin
    idle();
    rst = 1'b0; rd_addr1 = '0; rd_addr2 = '0; wb_addr = '0; wb_data = '0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 'x;
    m_pv = 1'b0; m_pa = '0; m_pd = '0; m_zq = 1'b0;
    @(negedge clk);
    step("init_rst");

    // Reset after random data: everything reads zero.
    idle();
    for (int i = 0; i < DEPTH; i++) begin
      write(ADDR_W'(i), DATA_W'($urandom));
      flag_en = 1'b1; zero_in = 1'b1;
      step("fill");
    end
    idle();
    rst = 1'b0;
    step("rst_a");
    step("rst_b");
    check("rst_pending", 32'(wb_pending), 32'd0);
    check("rst_zero_q", 32'(zero_q), 32'd0);
    rst = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      rd_addr1 = ADDR_W'(i); rd_addr2 = ADDR_W'(DEPTH - 1 - i);
      #1;
      check("rst_rd1", 32'(rd_data1), 32'h0);
      check("rst_rd2", 32'(rd_data2), 32'h0);
    end

    // Forwarding then commit of r3.
    idle();
    write(3'd3, 16'h0042);
    step("pre3");
    idle();
    step("pre3_commit");
    rd_addr1 = 3'd3;
    write(3'd3, 16'h1234);
    #1;
    check("fwd_old", 32'(rd_data1), 32'h0042);
    step("fwd_n");
    check("fwd_n_val", 32'(rd_data1), 32'h1234);
    check("fwd_n_pend", 32'(wb_pending), 32'd1);
    idle();
    step("fwd_n1");
    check("fwd_n1_val", 32'(rd_data1), 32'h1234);
    check("fwd_n1_pend", 32'(wb_pending), 32'd0);

    // Back-to-back writes to r5, both ports reading r5.
    rd_addr1 = 3'd5; rd_addr2 = 3'd5;
    write(3'd5, 16'hAAAA);
    step("b2b_a");
    check("b2b_a_val", 32'(rd_data2), 32'hAAAA);
    write(3'd5, 16'h5555);
    step("b2b_b");
    check("b2b_b_val", 32'(rd_data2), 32'h5555);
    idle();
    step("b2b_c");
    step("b2b_d");
    check("b2b_array", 32'(rd_data2), 32'h5555);

    // Hold blocks capture and flag update but not an in-flight commit.
    rd_addr1 = 3'd2; rd_addr2 = 3'd6;
    write(3'd6, 16'h6666);
    step("hold_pre");
    hold = 1'b1; write(3'd2, 16'hBEEF); flag_en = 1'b1; zero_in = 1'b1;
    step("hold_a");
    check("hold_r2", 32'(rd_data1), 32'h0000);
    check("hold_r6", 32'(rd_data2), 32'h6666);
    check("hold_zq", 32'(zero_q), 32'd0);
    check("hold_pend", 32'(wb_pending), 32'd0);
    step("hold_b");
    hold = 1'b0;

    // Zero flag set, hold-by-disable, clear.
    idle();
    flag_en = 1'b1; zero_in = 1'b1;
    step("zf_set");
    check("zf_set_v", 32'(zero_q), 32'd1);
    flag_en = 1'b0; zero_in = 1'b0;
    step("zf_keep");
    check("zf_keep_v", 32'(zero_q), 32'd1);
    flag_en = 1'b1; zero_in = 1'b0;
    step("zf_clr");
    check("zf_clr_v", 32'(zero_q), 32'd0);

    // Reset on the edge after a capture loses the pending write.
    idle();
    rd_addr1 = 3'd1;
    write(3'd1, 16'h7777);
    step("mid_cap");
    idle();
    rst = 1'b0;
    step("mid_rst");
    rst = 1'b1;
    step("mid_after");
    check("mid_r1", 32'(rd_data1), 32'h0000);

    // Randomised traffic against the model.
    for (int i = 0; i < 200; i++) begin
      rst      = ($urandom_range(0, 24) != 0);
      hold     = ($urandom_range(0, 3) == 0);
      wb_en    = ($urandom_range(0, 2) != 0);
      wb_addr  = ADDR_W'($urandom);
      wb_data  = DATA_W'($urandom);
      flag_en  = $urandom_range(0, 1) == 1;
      zero_in  = $urandom_range(0, 1) == 1;
      rd_addr1 = ADDR_W'($urandom);
      rd_addr2 = ($urandom_range(0, 1) == 1) ? wb_addr : ADDR_W'($urandom);
      step("rand");
    end

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
